// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Sequencing controller for the multi-cycle MIPS core. A Moore FSM steps the
//   shared datapath (single memory, single ALU, IR/ALUOut/MDR registers)
//   through fetch, decode, execute, memory and writeback. The supported
//   instructions are R-type (add/sub/and/or/slt), addi, andi, beq, bne, lw, sw
//   and j. The memory states (FETCH, MEM_RD, MEM_WR) hold until mem_ready is
//   seen. A wait counter bounds each hold to WAIT_LIMIT cycles.
//
// Parameters
//   WAIT_LIMIT    max cycles a memory state waits for mem_ready (1..255)
//   CNT_W         width of the retired-instruction counter
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   opcode[5:0]   IR[31:26], stable outside FETCH
//   mem_ready     memory access completes this cycle
//   pc_write      unconditional PC load
//   pc_write_beq  PC load if ALU zero
//   pc_write_bne  PC load if ALU not zero
//   iord          0=PC addresses memory, 1=ALUOut
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   ir_write      IR load
//   mem_to_reg    1=ALUOut to register file, 0=MDR
//   reg_dst       1=rd, 0=rt
//   reg_write     register file write
//   alu_src_a     0=PC, 1=reg A
//   alu_src_b     00=reg B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   alu_op        00=add, 01=sub, 10=funct, 11=and
//   pc_source     00=ALU result, 01=ALUOut, 10=jump target
//   state[3:0]    current state code (debug)
//   illegal_op    high in DECODE when the opcode is unsupported
//   mem_timeout   one-cycle registered pulse after a memory wait timeout
//   instr_count   retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_beq,
  output logic             pc_write_bne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EX     = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t             r_state;
  state_t             r_next;
  logic [7:0]         r_wait_cnt;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_instr_count;

  logic               w_is_wait;
  logic               w_timeout;
  logic               w_wait_hold;
  logic               w_retire;

  // Memory-wait bookkeeping. A ready in the same cycle as the limit takes
  // priority over the timeout.
  assign w_is_wait   = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  assign w_timeout   = w_is_wait && !mem_ready && (r_wait_cnt == LIMIT_M1);
  assign w_wait_hold = w_is_wait && !mem_ready && !w_timeout;

  // An instruction retires on the transition back to FETCH from a final
  // state. A timed-out store also returns to FETCH but does not retire.
  assign w_retire = (r_state == S_LW_WB) || (r_state == S_R_WB) ||
                    (r_state == S_I_WB)  || (r_state == S_BRANCH) ||
                    (r_state == S_JUMP)  ||
                    ((r_state == S_MEM_WR) && mem_ready);

  // State register and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state       <= r_next;
      // Every exit from a hold, including a FETCH re-entry after a timeout,
      // is treated as a fresh entry. That exit clears the counter.
      r_wait_cnt    <= w_wait_hold ? r_wait_cnt + 8'd1 : '0;
      r_mem_timeout <= w_timeout;
      if (w_retire) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    r_next = S_FETCH;
    case (r_state)
      S_FETCH:    r_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:        r_next = S_R_EX;
          OP_ADDI, OP_ANDI: r_next = S_I_EX;
          OP_BEQ, OP_BNE:  r_next = S_BRANCH;
          OP_LW, OP_SW:    r_next = S_MEM_ADDR;
          OP_J:            r_next = S_JUMP;
          default:         r_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: r_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      r_next = S_LW_WB;
        else if (w_timeout) r_next = S_FETCH;
        else                r_next = S_MEM_RD;
      end
      S_MEM_WR:   r_next = (mem_ready || w_timeout) ? S_FETCH : S_MEM_WR;
      S_R_EX:     r_next = S_R_WB;
      S_I_EX:     r_next = S_I_WB;
      S_LW_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: r_next = S_FETCH;
      default:    r_next = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_source    = 2'b00;
    illegal_op   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE,
          OP_LW, OP_SW, OP_J: illegal_op = 1'b0;
          default:            illegal_op = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b01;
        pc_source    = 2'b01;
        pc_write_beq = (opcode == OP_BEQ);
        pc_write_bne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    // Write strobes are masked as soon as reset asserts. This masking does
    // not wait for the clock, so no partial write escapes mid-instruction.
    if (reset) begin
      pc_write     = 1'b0;
      pc_write_beq = 1'b0;
      pc_write_bne = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
    end
  end

  assign state       = r_state;
  assign mem_timeout = r_mem_timeout;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Bench for multicycle_ctrl_fsm. For each instruction, the expected per-cycle
//   trace is built from its class: the path of state codes plus the memory
//   waits. A short counter width is used so that wrap-around can be reached.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam int unsigned WL  = 15;
  localparam int unsigned CW  = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          illegal_op, mem_timeout;
  logic [CW-1:0] instr_count;

  multicycle_ctrl_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       to;
  } ent_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned model_cnt = 0;
  logic        exp_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Starts and ends at a falling edge. Each trace entry is applied there and
  // sampled 1ns later.
  task automatic run_instr(input logic [5:0] op, input int unsigned d_f,
                           input bit f_to, input int unsigned d_m);
    ent_t q[$];
    bit   illegal = 1'b0;
    bit   timed_out = 1'b0;
    logic [3:0] mst;
    if (f_to)
      for (int unsigned i = 0; i < WL; i++) q.push_back('{4'd0, 1'b0, i == WL - 1});
    for (int unsigned i = 0; i < d_f; i++) q.push_back('{4'd0, 1'b0, 1'b0});
    q.push_back('{4'd0, 1'b1, 1'b0});
    q.push_back('{4'd1, 1'($urandom), 1'b0});
    case (op)
      OP_R:             begin q.push_back('{4'd6, 1'b1, 1'b0}); q.push_back('{4'd7, 1'b0, 1'b0}); end
      OP_ADDI, OP_ANDI: begin q.push_back('{4'd8, 1'b0, 1'b0}); q.push_back('{4'd9, 1'b1, 1'b0}); end
      OP_BEQ, OP_BNE:   q.push_back('{4'd10, 1'($urandom), 1'b0});
      OP_J:             q.push_back('{4'd11, 1'($urandom), 1'b0});
      OP_LW, OP_SW: begin
        q.push_back('{4'd2, 1'($urandom), 1'b0});
        mst = (op == OP_LW) ? 4'd3 : 4'd5;
        if (d_m >= WL) begin
          timed_out = 1'b1;
          for (int unsigned i = 0; i < WL; i++) q.push_back('{mst, 1'b0, i == WL - 1});
        end else begin
          for (int unsigned i = 0; i < d_m; i++) q.push_back('{mst, 1'b0, 1'b0});
          q.push_back('{mst, 1'b1, 1'b0});
          if (op == OP_LW) q.push_back('{4'd4, 1'($urandom), 1'b0});
        end
      end
      default: illegal = 1'b1;
    endcase

    check("instr_count", 32'(instr_count), 32'(model_cnt % (1 << CW)));
    opcode = op;
    foreach (q[k]) begin
      logic [3:0] s;
      logic       r;
      s = q[k].st;
      r = q[k].rdy;
      mem_ready = r;
      #1;
      check("state",      32'(state),        32'(s));
      check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
      check("reg_write",  32'(reg_write),    32'(s == 4 || s == 7 || s == 9));
      check("reg_dst",    32'(reg_dst),      32'(s == 7));
      check("mem_to_reg", 32'(mem_to_reg),   32'(s == 7 || s == 9));
      check("mem_write",  32'(mem_write),    32'(s == 5));
      check("mem_read",   32'(mem_read),     32'(s == 0 || s == 3));
      check("iord",       32'(iord),         32'(s == 3 || s == 5));
      check("pc_write",   32'(pc_write),     32'((s == 0 && r) || s == 11));
      check("ir_write",   32'(ir_write),     32'(s == 0 && r));
      check("pc_wr_beq",  32'(pc_write_beq), 32'(s == 10 && op == OP_BEQ));
      check("pc_wr_bne",  32'(pc_write_bne), 32'(s == 10 && op == OP_BNE));
      check("pc_source",  32'(pc_source),    (s == 10) ? 32'd1 : (s == 11) ? 32'd2 : 32'd0);
      check("alu_op",     32'(alu_op),       (s == 6) ? 32'd2 : (s == 10) ? 32'd1 :
                                             (s == 8 && op == OP_ANDI) ? 32'd3 : 32'd0);
      check("alu_src_a",  32'(alu_src_a),    32'(s == 2 || s == 6 || s == 8 || s == 10));
      check("alu_src_b",  32'(alu_src_b),    (s == 0) ? 32'd1 : (s == 1) ? 32'd3 :
                                             (s == 2 || s == 8) ? 32'd2 : 32'd0);
      check("illegal_op", 32'(illegal_op),   32'(s == 1 && illegal));
      exp_to = q[k].to;
      @(negedge clk);
    end
    if (!illegal && !timed_out) model_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    reset = 1'b0;
    model_cnt = 0;
    exp_to = 1'b0;
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{OP_R, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J,
            6'b111111, 6'b000011};
    reset = 1'b1;
    opcode = '0;
    mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed cases
    run_instr(OP_R, 0, 1'b0, 0);
    check("count_after_add", 32'(instr_count), 32'd1);
    run_instr(OP_LW, 0, 1'b0, 3);
    run_instr(OP_LW, 2, 1'b0, WL - 1);
    run_instr(OP_SW, 0, 1'b0, 20);
    run_instr(OP_BNE, 0, 1'b0, 0);
    run_instr(OP_J, 0, 1'b0, 0);
    run_instr(6'b111111, 0, 1'b0, 0);
    run_instr(OP_BEQ, 1, 1'b1, 0);
    run_instr(OP_ANDI, 0, 1'b0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      int unsigned dm;
      dm = ($urandom_range(0, 4) == 0) ? $urandom_range(WL - 1, WL + 3) : $urandom_range(0, 4);
      run_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3),
                $urandom_range(0, 9) == 0, dm);
    end

    // Counter wrap
    do_reset();
    for (int n = 0; n < 17; n++) run_instr(OP_J, 0, 1'b0, 0);
    check("wrap_count", 32'(instr_count), 32'(17 % (1 << CW)));

    // Reset in the middle of an R-type writeback
    opcode = OP_R;
    mem_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
      check("pre_rst_state", 32'(state), (k == 0) ? 32'd0 : (k == 1) ? 32'd1 :
                                         (k == 2) ? 32'd6 : 32'd7);
      if (k < 3) @(negedge clk);
    end
    check("rwb_reg_write", 32'(reg_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_regw", 32'(reg_write), 32'd0);
    check("mid_rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    check("mid_rst_pcw", 32'(pc_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
